// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle parametrised ALU with start/busy/done handshake and restoring divider
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int CNTW  = $clog2(WIDTH) + 1
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       aluOP,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] O,
    output logic             less_than,
    output logic             zero,
    output logic             div_by_zero
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b0010;
    localparam logic [3:0] OP_NOR  = 4'b0011;
    localparam logic [3:0] OP_SLT  = 4'b0100;
    localparam logic [3:0] OP_ADD  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_MOD  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1100;
    localparam logic [3:0] OP_DIV  = 4'b1111;

    typedef enum logic [1:0] {IDLE, DIV, FIN} state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_accept;
    logic             w_div_in;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [3:0]       r_op;
    logic [CNTW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;

    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_o;
    logic             r_lt;
    logic             r_zero;
    logic             r_dbz;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_qbit;
    logic             w_lt;
    logic             w_ltu;
    logic             w_dbz;
    logic [WIDTH-1:0] w_result;

    assign w_div_in = (aluOP == OP_MOD) || (aluOP == OP_DIV);

    // FIN doubles as an accept state so single-cycle ops can stream one per cycle
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            IDLE, FIN: begin
                w_next = IDLE;
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = (w_div_in && (b != '0)) ? DIV : FIN;
                end
            end
            DIV: begin
                if (r_cnt == CNTW'(1)) begin
                    w_next = FIN;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Partial remainder carries one extra bit so the trial subtraction never overflows
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_b};
    assign w_qbit  = ~w_diff[WIDTH];

    assign w_lt  = $signed(r_a) < $signed(r_b);
    assign w_ltu = r_a < r_b;
    assign w_dbz = ((r_op == OP_MOD) || (r_op == OP_DIV)) && (r_b == '0);

    always_comb begin
        w_result = '0;
        case (r_op)
            OP_AND:  w_result = r_a & r_b;
            OP_OR:   w_result = r_a | r_b;
            OP_XOR:  w_result = r_a ^ r_b;
            OP_NOR:  w_result = ~(r_a | r_b);
            OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, w_lt};
            OP_ADD:  w_result = r_a + r_b;
            OP_SUB:  w_result = r_a - r_b;
            OP_MOD:  w_result = (r_b == '0) ? r_a : r_rem;
            OP_SLTU: w_result = {{(WIDTH-1){1'b0}}, w_ltu};
            OP_DIV:  w_result = (r_b == '0) ? '1 : r_quo;
            default: w_result = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_a    <= '0;
            r_b    <= '0;
            r_op   <= '0;
            r_cnt  <= '0;
            r_rem  <= '0;
            r_quo  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_o    <= '0;
            r_lt   <= 1'b0;
            r_zero <= 1'b0;
            r_dbz  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a   <= a;
                r_b   <= b;
                r_op  <= aluOP;
                r_rem <= '0;
                r_quo <= a;
                r_cnt <= CNTW'(WIDTH);
            end else if (r_state == DIV) begin
                r_rem <= w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
                r_quo <= {r_quo[WIDTH-2:0], w_qbit};
                r_cnt <= r_cnt - CNTW'(1);
            end
            r_done <= (r_state == FIN);
            r_busy <= (w_next != IDLE) && (r_state != FIN);
            if (r_state == FIN) begin
                r_o    <= w_result;
                r_lt   <= w_lt;
                r_zero <= (w_result == '0);
                r_dbz  <= w_dbz;
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign O           = r_o;
    assign less_than   = r_lt;
    assign zero        = r_zero;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed scoreboard bench for alu_seq at WIDTH=32 and WIDTH=8
module tb_alu_seq;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        rst_n;
    logic        s32, busy32, done32, lt32, z32, dz32;
    logic [3:0]  op32;
    logic [31:0] a32, b32, o32;
    logic        s8, busy8, done8, lt8, z8, dz8;
    logic [3:0]  op8;
    logic [7:0]  a8, b8, o8;

    alu_seq #(.WIDTH(32)) u_dut32 (
        .CLK(CLK), .reset(rst_n), .start(s32), .aluOP(op32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .O(o32), .less_than(lt32), .zero(z32), .div_by_zero(dz32)
    );

    alu_seq #(.WIDTH(8)) u_dut8 (
        .CLK(CLK), .reset(rst_n), .start(s8), .aluOP(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .O(o8), .less_than(lt8), .zero(z8), .div_by_zero(dz8)
    );

    typedef struct packed {
        logic [31:0] o;
        logic        lt;
        logic        z;
        logic        dz;
    } exp_t;

    exp_t        q32[$];
    exp_t        q8[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int          nb32, nb8;
    int unsigned t;

    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    function automatic exp_t model(input int w, input logic [3:0] op, input logic [31:0] ai, input logic [31:0] bi);
        exp_t        e;
        logic [31:0] m, x, y;
        int          sa, sb;
        m  = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
        x  = ai & m;
        y  = bi & m;
        sa = (w == 32) ? int'(x) : int'({{24{x[7]}}, x[7:0]});
        sb = (w == 32) ? int'(y) : int'({{24{y[7]}}, y[7:0]});
        e.lt = (sa < sb);
        e.dz = ((op == 4'b0111) || (op == 4'b1111)) && (y == 0);
        case (op)
            4'b0000: e.o = x & y;
            4'b0001: e.o = x | y;
            4'b0010: e.o = x ^ y;
            4'b0011: e.o = ~(x | y) & m;
            4'b0100: e.o = {31'b0, e.lt};
            4'b0101: e.o = (x + y) & m;
            4'b0110: e.o = (x - y) & m;
            4'b0111: e.o = (y == 0) ? x : x % y;
            4'b1100: e.o = {31'b0, x < y};
            4'b1111: e.o = (y == 0) ? m : x / y;
            default: e.o = 32'h0;
        endcase
        e.z = (e.o == 0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic issue32(input logic [3:0] op, input logic [31:0] ai, input logic [31:0] bi, output int unsigned t_acc);
        s32 = 1'b1; op32 = op; a32 = ai; b32 = bi;
        q32.push_back(model(32, op, ai, bi));
        @(posedge CLK); @(negedge CLK);
        s32 = 1'b0; op32 = 4'($urandom); a32 = $urandom; b32 = $urandom;
        t_acc = cyc;
        nb32 = busy32 ? 1 : 0;
    endtask

    task automatic issue8(input logic [3:0] op, input logic [7:0] ai, input logic [7:0] bi, output int unsigned t_acc);
        s8 = 1'b1; op8 = op; a8 = ai; b8 = bi;
        q8.push_back(model(8, op, {24'b0, ai}, {24'b0, bi}));
        @(posedge CLK); @(negedge CLK);
        s8 = 1'b0; op8 = 4'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
        t_acc = cyc;
        nb8 = busy8 ? 1 : 0;
    endtask

    task automatic cmp32(input string tag);
        exp_t e;
        chk({tag, " done"}, 32'(done32), 32'd1);
        chk({tag, " busy"}, 32'(busy32), 32'd0);
        if (q32.size() != 0) begin
            e = q32.pop_front();
            chk({tag, " O"}, o32, e.o);
            chk({tag, " lt"}, 32'(lt32), 32'(e.lt));
            chk({tag, " zero"}, 32'(z32), 32'(e.z));
            chk({tag, " dbz"}, 32'(dz32), 32'(e.dz));
        end
    endtask

    task automatic cmp8(input string tag);
        exp_t e;
        chk({tag, " done"}, 32'(done8), 32'd1);
        chk({tag, " busy"}, 32'(busy8), 32'd0);
        if (q8.size() != 0) begin
            e = q8.pop_front();
            chk({tag, " O"}, {24'b0, o8}, e.o);
            chk({tag, " lt"}, 32'(lt8), 32'(e.lt));
            chk({tag, " zero"}, 32'(z8), 32'(e.z));
            chk({tag, " dbz"}, 32'(dz8), 32'(e.dz));
        end
    endtask

    task automatic wait32(input string tag, input int unsigned t_acc, input int lat, input int busy_cycles);
        int n = 0;
        while (!done32 && n < 100) begin
            @(posedge CLK); @(negedge CLK);
            n++;
            if (busy32) nb32++;
        end
        chk({tag, " latency"}, cyc - t_acc, 32'(lat));
        if (busy_cycles >= 0) chk({tag, " busy_cycles"}, 32'(nb32), 32'(busy_cycles));
        cmp32(tag);
    endtask

    task automatic wait8(input string tag, input int unsigned t_acc, input int lat);
        int n = 0;
        while (!done8 && n < 100) begin
            @(posedge CLK); @(negedge CLK);
            n++;
        end
        chk({tag, " latency"}, cyc - t_acc, 32'(lat));
        cmp8(tag);
    endtask

    initial begin
        int saw_done;
        rst_n = 1'b0;
        s32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
        s8  = 1'b0; op8  = '0; a8  = '0; b8  = '0;
        repeat (2) @(negedge CLK);
        chk("rst busy32", 32'(busy32), 32'd0);
        chk("rst done32", 32'(done32), 32'd0);
        chk("rst O32", o32, 32'd0);
        chk("rst flags32", {29'b0, lt32, z32, dz32}, 32'd0);
        chk("rst O8", {24'b0, o8}, 32'd0);
        rst_n = 1'b1;
        @(negedge CLK);

        issue32(4'b0101, 32'd7, 32'd5, t);                 wait32("add", t, 1, 1);
        issue32(4'b0101, 32'hFFFF_FFFF, 32'd1, t);         wait32("add_wrap", t, 1, -1);
        issue32(4'b0111, 32'd100, 32'd7, t);               wait32("mod", t, 33, 33);
        issue32(4'b1111, 32'd100, 32'd7, t);               wait32("div", t, 33, 33);
        issue32(4'b0111, 32'd9, 32'd0, t);                 wait32("mod_b0", t, 1, 1);
        issue32(4'b1111, 32'd9, 32'd0, t);                 wait32("div_b0", t, 1, -1);
        issue32(4'b0000, 32'h0000_F0F0, 32'h0000_FF00, t); wait32("and", t, 1, -1);
        issue32(4'b0100, 32'hFFFF_FFFF, 32'd1, t);         wait32("slt", t, 1, -1);
        issue32(4'b1100, 32'hFFFF_FFFF, 32'd1, t);         wait32("sltu", t, 1, -1);
        issue32(4'b0011, 32'd0, 32'd0, t);                 wait32("nor", t, 1, -1);
        issue32(4'b1010, 32'd3, 32'd9, t);                 wait32("undef", t, 1, -1);
        issue32(4'b0110, 32'd5, 32'd9, t);                 wait32("sub", t, 1, -1);

        issue32(4'b1111, 32'd1000, 32'd3, t);
        repeat (4) @(negedge CLK);
        s32 = 1'b1; op32 = 4'b0101; a32 = 32'd1; b32 = 32'd1;
        @(negedge CLK);
        s32 = 1'b0;
        wait32("div_ignore", t, 33, -1);

        issue8(4'b1111, 8'd200, 8'd3, t);                  wait8("div8", t, 9);
        issue8(4'b0111, 8'd200, 8'd3, t);                  wait8("mod8", t, 9);
        issue8(4'b0110, 8'd3, 8'd5, t);                    wait8("sub8", t, 1);
        issue8(4'b0100, 8'hFF, 8'd1, t);                   wait8("slt8", t, 1);

        s8 = 1'b1; op8 = 4'b0010; a8 = 8'h0F; b8 = 8'hF0;
        q8.push_back(model(8, 4'b0010, 32'h0F, 32'hF0));
        @(posedge CLK); @(negedge CLK);
        a8 = 8'h55; b8 = 8'h0F;
        q8.push_back(model(8, 4'b0010, 32'h55, 32'h0F));
        @(posedge CLK); @(negedge CLK);
        cmp8("b2b1");
        a8 = 8'hAA; b8 = 8'hAA;
        q8.push_back(model(8, 4'b0010, 32'hAA, 32'hAA));
        @(posedge CLK); @(negedge CLK);
        cmp8("b2b2");
        s8 = 1'b0;
        @(posedge CLK); @(negedge CLK);
        cmp8("b2b3");
        @(posedge CLK); @(negedge CLK);
        chk("b2b idle done", 32'(done8), 32'd0);

        issue32(4'b1111, 32'd1000, 32'd3, t);
        repeat (8) @(negedge CLK);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst busy", 32'(busy32), 32'd0);
        chk("mid_rst done", 32'(done32), 32'd0);
        chk("mid_rst O", o32, 32'd0);
        chk("mid_rst flags", {29'b0, lt32, z32, dz32}, 32'd0);
        q32.delete();
        @(negedge CLK);
        rst_n = 1'b1;
        saw_done = 0;
        repeat (40) begin
            @(negedge CLK);
            if (done32) saw_done++;
        end
        chk("mid_rst no_done", 32'(saw_done), 32'd0);
        issue32(4'b0101, 32'd2, 32'd2, t);                 wait32("add_after_rst", t, 1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the existing 32-bit combinational/mod ALU. Datapath width is generic.
- Adds a start/busy/done handshake, a 4-bit opcode that keeps the legacy 3-bit encoding, unsigned divide, unsigned compare, divide-by-zero handling and status flags.
- Sits between operand registers and the writeback stage. A controller issues one operation at a time.

Parameters:
- WIDTH, 32, operand/result width in bits (≥4).
- CNTW, $clog2(WIDTH)+1, width of the division iteration counter.

Ports:
- CLK  input  1  system clock; rising edge active.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled on the rising CLK edge while not busy.
- aluOP  input  4  opcode, latched with start.
- a  input  WIDTH  operand A, latched with start.
- b  input  WIDTH  operand B, latched with start.
- busy  output  1  operation in flight; start is ignored while high.
- done  output  1  one-cycle pulse; O and flags valid from this cycle on.
- O  output  WIDTH  registered result, held until the next done.
- less_than  output  1  registered signed (A<B) of the latched operands.
- zero  output  1  registered (O==0).
- div_by_zero  output  1  registered; high when a MOD/DIV had B==0.

Behaviour:
- Opcodes with aluOP[3]=0 keep the legacy encoding:
  - 0000 AND, 0001 OR, 0010 XOR, 0011 NOR.
  - 0100 SLT signed: O = {0…, A<B}.
  - 0101 ADD, 0110 SUB (A−B).
  - 0111 MOD: unsigned remainder.
- Opcodes with aluOP[3]=1:
  - 1100 SLTU: unsigned compare.
  - 1111 DIV: unsigned quotient.
  - All other codes are undefined: O=0, flags computed normally, single-cycle latency.
- ADD/SUB wrap modulo 2^WIDTH. There is no carry/overflow output.
- reset low forces these values immediately, regardless of CLK:
  - state=IDLE.
  - busy=0, done=0, O=0, less_than=0, zero=0, div_by_zero=0.
  - Internal counter, remainder and quotient registers cleared.
- State machine states: IDLE, DIV, FIN.
- IDLE:
  - On an edge with start=1: latch a, b and aluOP.
  - Single-cycle op → go to FIN.
  - MOD/DIV with B≠0 → go to DIV with counter=WIDTH.
  - MOD/DIV with B==0 → go to FIN.
- DIV: restoring shift-subtract, one quotient bit per edge, MSB first.
  - Counter decrements each edge; at counter==1 → FIN.
  - Exactly WIDTH edges are spent in DIV.
- FIN: one edge. It registers O, less_than, zero and div_by_zero, pulses done, then returns to IDLE.
- busy:
  - Goes high on the edge that accepts start.
  - Stays high through DIV.
  - Goes low on the edge that asserts done, so busy=0 while done=1.
- Latency, counted from the accepting edge N:
  - Single-cycle ops and B==0 cases: done is high in the cycle after edge N+1.
  - MOD/DIV with B≠0: done is high after edge N+WIDTH+1.
- Back-to-back: start asserted during the done cycle is accepted on the next edge. The FIN→IDLE edge is also the accept edge, giving full throughput for single-cycle ops.
- start while busy: ignored. The latched operands and opcode are not disturbed.
- Divide by zero:
  - DIV → O = all ones.
  - MOD → O = A.
  - div_by_zero=1.
  - div_by_zero clears on the next done for any op with a nonzero divisor or a non-divide op.
- less_than and zero are updated on every done, whatever the opcode.
- A reset asserted mid-division aborts the operation. No done is issued, and all outputs follow the reset values above.
- Inputs a, b and aluOP may change freely after the accepting edge.

Test Plan:
- WIDTH=32. ADD a=7, b=5, start at edge N → done after N+1, O=12, zero=0. ADD 0xFFFFFFFF+1 → O=0, zero=1.
- WIDTH=32. MOD a=100, b=7 → done exactly after edge N+33, O=2, busy high for 33 cycles. DIV a=100, b=7 → O=14.
- WIDTH=32. MOD a=9, b=0 → done after N+1, O=9, div_by_zero=1. Then DIV a=9, b=0 → O=0xFFFFFFFF, div_by_zero=1. Then AND 0xF0F0&0xFF00 → O=0xF000, div_by_zero=0.
- WIDTH=32. SLT a=0xFFFFFFFF, b=1 → O=1, less_than=1. SLTU with the same operands → O=0, less_than=1. NOR a=0, b=0 → O=0xFFFFFFFF.
- WIDTH=32. Start DIV a=1000, b=3. Assert start with ADD at cycle 5 → ignored, final O=333. Repeat the DIV and pull reset low at cycle 10 → busy=0, O=0, no done. After release, ADD 2+2 → O=4.
- WIDTH=8 instance. DIV 200/3 → O=66, latency 9 cycles. MOD 200%3 → O=2. SUB 3−5 → O=0xFE. Back-to-back XOR ops issued on consecutive done cycles → one done per cycle.
